// File: rtl/fi_campaign_ctrl.sv
// Purpose : sequences a fault-injection campaign over a golden/faulty pair of circuit-under-test copies.
// Latency : every output is registered; a run spans 2*N_FF+2 cycles (RPH, N_FF x RAND, INJ, N_FF x OBS).
// Backpres: no handshake; start is ignored while busy, abort returns to IDLE on the next cycle.
//
// Ports:
//   CK, RST          clock, synchronous active-low reset
//   start, abort     campaign control requests
//   gd_out, fl_out   golden / faulty outputs; any differing bit during OBS flags the run
//   stim             LFSR stimulus shared by both instances (0 outside RAND/INJ/OBS)
//   dut_rst          reset to both instances, high only in RPH
//   inj_en, inj_sel  one-cycle injection strobe and the target it applies to
//   busy, done       campaign status
//   run_done/run_det end-of-run pulse and that run's detection result
//   run_cnt, det_cnt completed and detected run counters (saturating)
module fi_campaign_ctrl #(
    parameter int          N_IN   = 4,
    parameter int          N_OUT  = 1,
    parameter int          N_FF   = 3,
    parameter int          N_TGT  = 8,
    parameter int          N_RUNS = 1000,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic                                        CK,
    input  logic                                        RST,
    input  logic                                        start,
    input  logic                                        abort,
    input  logic [N_OUT-1:0]                            gd_out,
    input  logic [N_OUT-1:0]                            fl_out,
    output logic [N_IN-1:0]                             stim,
    output logic                                        dut_rst,
    output logic                                        inj_en,
    output logic [((N_TGT > 1) ? $clog2(N_TGT) : 1)-1:0] inj_sel,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        run_done,
    output logic                                        run_det,
    output logic [15:0]                                 run_cnt,
    output logic [15:0]                                 det_cnt
);

    localparam int TW = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    // Phase counter spans 0..N_FF-1 in RAND and OBS.
    localparam int PW = (N_FF > 1) ? $clog2(N_FF) : 1;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RPH,
        S_RAND,
        S_INJ,
        S_OBS,
        S_DONE
    } state_t;

    state_t          state_q,    state_d;
    logic [PW-1:0]   phase_q,    phase_d;
    logic [15:0]     lfsr_q,     lfsr_d;
    logic            sticky_q,   sticky_d;
    logic [TW-1:0]   inj_sel_q,  inj_sel_d;
    logic [15:0]     run_cnt_q,  run_cnt_d;
    logic [15:0]     det_cnt_q,  det_cnt_d;
    logic [N_IN-1:0] stim_q,     stim_d;
    logic            dut_rst_q,  dut_rst_d;
    logic            inj_en_q,   inj_en_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            run_done_q, run_done_d;
    logic            run_det_q,  run_det_d;

    logic            miss;
    logic            run_det_w;
    logic            phase_last;
    logic            in_busy;
    logic [15:0]     lfsr_next;
    logic [15:0]     run_cnt_inc;
    logic [15:0]     det_cnt_inc;

    // Only feeds registered state, so there is no combinational path to any output.
    assign miss        = |(gd_out ^ fl_out);
    // Include the current sample so a mismatch in the last OBS cycle still counts.
    assign run_det_w   = sticky_q | miss;
    assign phase_last  = (phase_q == PW'(N_FF - 1));
    assign in_busy     = (state_q == S_RPH) || (state_q == S_RAND) ||
                         (state_q == S_INJ) || (state_q == S_OBS);
    // Galois right shift: the bit leaving at [0] folds the tap mask back in.
    assign lfsr_next   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    assign run_cnt_inc = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_cnt_q + 16'd1;
    assign det_cnt_inc = (det_cnt_q == 16'hFFFF) ? det_cnt_q : det_cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        sticky_d   = sticky_q;
        inj_sel_d  = inj_sel_q;
        run_cnt_d  = run_cnt_q;
        det_cnt_d  = det_cnt_q;
        run_done_d = 1'b0;
        run_det_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // abort wins over a simultaneous start.
                if (start && !abort) begin
                    state_d   = S_RPH;
                    run_cnt_d = 16'd0;
                    det_cnt_d = 16'd0;
                    inj_sel_d = '0;
                    sticky_d  = 1'b0;
                end
            end
            S_RPH: begin
                state_d = S_RAND;
                phase_d = '0;
            end
            S_RAND: begin
                if (phase_last) begin
                    state_d = S_INJ;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_INJ: begin
                state_d = S_OBS;
                phase_d = '0;
            end
            S_OBS: begin
                if (miss) begin
                    sticky_d = 1'b1;
                end
                if (phase_last) begin
                    // Run bookkeeping lands in the cycle that is already the next RPH (or DONE).
                    run_done_d = 1'b1;
                    run_det_d  = run_det_w;
                    run_cnt_d  = run_cnt_inc;
                    if (run_det_w) begin
                        det_cnt_d = det_cnt_inc;
                    end
                    sticky_d  = 1'b0;
                    inj_sel_d = (inj_sel_q == TW'(N_TGT - 1)) ? '0 : inj_sel_q + TW'(1);
                    state_d   = (32'(run_cnt_d) >= N_RUNS) ? S_DONE : S_RPH;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort discards the run in flight: counters and target hold, no end-of-run pulse.
        if (in_busy && abort) begin
            state_d    = S_IDLE;
            sticky_d   = 1'b0;
            inj_sel_d  = inj_sel_q;
            run_cnt_d  = run_cnt_q;
            det_cnt_d  = det_cnt_q;
            run_done_d = 1'b0;
            run_det_d  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        lfsr_d    = lfsr_q;
        stim_d    = '0;
        busy_d    = (state_d == S_RPH) || (state_d == S_RAND) ||
                    (state_d == S_INJ) || (state_d == S_OBS);
        done_d    = (state_d == S_DONE);
        dut_rst_d = (state_d == S_RPH);
        inj_en_d  = (state_d == S_INJ);
        // The LFSR steps once per cycle of stimulus and never reloads outside reset.
        if ((state_d == S_RAND) || (state_d == S_INJ) || (state_d == S_OBS)) begin
            stim_d = lfsr_q[N_IN-1:0];
            lfsr_d = lfsr_next;
        end
    end

    always_ff @(posedge CK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            lfsr_q     <= SEED;
            sticky_q   <= 1'b0;
            inj_sel_q  <= '0;
            run_cnt_q  <= 16'd0;
            det_cnt_q  <= 16'd0;
            stim_q     <= '0;
            dut_rst_q  <= 1'b0;
            inj_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            run_done_q <= 1'b0;
            run_det_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            lfsr_q     <= lfsr_d;
            sticky_q   <= sticky_d;
            inj_sel_q  <= inj_sel_d;
            run_cnt_q  <= run_cnt_d;
            det_cnt_q  <= det_cnt_d;
            stim_q     <= stim_d;
            dut_rst_q  <= dut_rst_d;
            inj_en_q   <= inj_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            run_done_q <= run_done_d;
            run_det_q  <= run_det_d;
        end
    end

    assign stim     = stim_q;
    assign dut_rst  = dut_rst_q;
    assign inj_en   = inj_en_q;
    assign inj_sel  = inj_sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign run_done = run_done_q;
    assign run_det  = run_det_q;
    assign run_cnt  = run_cnt_q;
    assign det_cnt  = det_cnt_q;

endmodule

// File: tb/tb_fi_campaign_ctrl.sv
// Purpose : directed self-checking bench for fi_campaign_ctrl (a default instance and a small N_TGT=3/N_RUNS=7 one).
// Latency : outputs sampled on the falling edge, half a cycle after the rising edge that produced them.
// Backpres: none; inputs are driven right after each falling edge.
module tb_fi_campaign_ctrl;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    // Small instance
    logic        rst_n, start, abort;
    logic [0:0]  gd_out, fl_out;
    logic [3:0]  stim;
    logic        dut_rst, inj_en, busy, done, run_done, run_det;
    logic [1:0]  inj_sel;
    logic [15:0] run_cnt, det_cnt;

    // Default instance, faulty output tied to golden
    logic        d_rst_n, d_start, d_abort;
    logic [0:0]  d_gd;
    logic [3:0]  d_stim;
    logic        d_dut_rst, d_inj_en, d_busy, d_done, d_run_done, d_run_det;
    logic [2:0]  d_inj_sel;
    logic [15:0] d_run_cnt, d_det_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;

    fi_campaign_ctrl #(.N_IN(4), .N_OUT(1), .N_FF(3), .N_TGT(3), .N_RUNS(7), .SEED(16'hACE1)) u_dut (
        .CK(CK), .RST(rst_n), .start(start), .abort(abort),
        .gd_out(gd_out), .fl_out(fl_out),
        .stim(stim), .dut_rst(dut_rst), .inj_en(inj_en), .inj_sel(inj_sel),
        .busy(busy), .done(done), .run_done(run_done), .run_det(run_det),
        .run_cnt(run_cnt), .det_cnt(det_cnt)
    );

    fi_campaign_ctrl u_def (
        .CK(CK), .RST(d_rst_n), .start(d_start), .abort(d_abort),
        .gd_out(d_gd), .fl_out(d_gd),
        .stim(d_stim), .dut_rst(d_dut_rst), .inj_en(d_inj_en), .inj_sel(d_inj_sel),
        .busy(d_busy), .done(d_done), .run_done(d_run_done), .run_det(d_run_det),
        .run_cnt(d_run_cnt), .det_cnt(d_det_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CK);
    endtask

    // Hand-computed from SEED=ACE1: lfsr ACE1,E270,7138,389C,1C4E,0E27,B313 -> low nibbles
    logic [3:0] exp_stim [8] = '{4'h0, 4'h1, 4'h0, 4'h8, 4'hC, 4'hE, 4'h7, 4'h3};

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; gd_out = 1'b1; fl_out = 1'b1;
        d_rst_n = 1'b0; d_start = 1'b0; d_abort = 1'b0; d_gd = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_busy",    32'(busy), 0);
        check("rst_done",    32'(done), 0);
        check("rst_stim",    32'(stim), 0);
        check("rst_dut_rst", 32'(dut_rst), 0);
        check("rst_inj_en",  32'(inj_en), 0);
        check("rst_pulses",  32'({run_done, run_det}), 0);
        check("rst_cnts",    {run_cnt, det_cnt}, 0);
        check("rst_inj_sel", 32'(inj_sel), 0);
        rst_n = 1'b1; d_rst_n = 1'b1;
        tick();

        // Full default campaign: done 8001 cycles after the start cycle
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        cyc = 1;
        while (!d_done && cyc < 9000) begin
            tick();
            cyc++;
        end
        check("def_done_latency", 32'(cyc), 8001);
        check("def_run_cnt",      32'(d_run_cnt), 1000);
        check("def_det_cnt",      32'(d_det_cnt), 0);
        check("def_busy",         32'(d_busy), 0);

        // Start, then reset in RAND together with abort and start
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rph_busy",    32'(busy), 1);
        check("rph_dut_rst", 32'(dut_rst), 1);
        check("rph_stim",    32'(stim), 0);
        tick();
        check("rand1_stim",  32'(stim), 32'h1);
        tick();
        rst_n = 1'b0; abort = 1'b1; start = 1'b1;
        tick();
        check("midrst_busy",     32'(busy), 0);
        check("midrst_run_done", 32'(run_done), 0);
        check("midrst_stim",     32'(stim), 0);
        check("midrst_cnts",     {run_cnt, det_cnt}, 0);
        rst_n = 1'b1; abort = 1'b0; start = 1'b0;
        tick();
        check("postrst_idle", 32'(busy), 0);

        // Full 7-run campaign; runs are counted from 1, mismatch only in OBS cycle 3 of run 2
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < 8; k++) begin
                if (k == 0) begin
                    check("run_done_pulse", 32'(run_done), 32'(r > 0));
                    if (r > 0) check("run_det", 32'(run_det), 32'(r == 2));
                    check("run_cnt", 32'(run_cnt), r);
                    check("det_cnt", 32'(det_cnt), 32'(r >= 2));
                end else begin
                    check("run_done_idle", 32'(run_done), 0);
                end
                check("dut_rst_phase", 32'(dut_rst), 32'(k == 0));
                check("inj_en_phase",  32'(inj_en), 32'(k == 4));
                if (k == 4) check("inj_sel_seq", 32'(inj_sel), r % 3);
                if (r == 0) check("stim_seq", 32'(stim), 32'(exp_stim[k]));
                fl_out = (r == 1 && k == 7) ? ~gd_out : gd_out;
                tick();
            end
        end
        fl_out = gd_out;
        check("done_flag",     32'(done), 1);
        check("done_busy",     32'(busy), 0);
        check("done_last_pulse", 32'({run_done, run_det}), 32'h2);
        check("done_cnts",     {run_cnt, det_cnt}, {16'd7, 16'd1});
        check("done_inj_sel",  32'(inj_sel), 1);
        check("done_stim",     32'(stim), 0);
        tick();
        check("done_hold",     32'({done, run_done}), 32'h2);
        check("done_hold_cnt", 32'(run_cnt), 7);

        // Restart from DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done_drop", 32'(done), 0);
        check("restart_busy",      32'(busy), 1);
        check("restart_cnts",      {run_cnt, det_cnt}, 0);
        check("restart_inj_sel",   32'(inj_sel), 0);

        // start while busy has no effect on timing
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("busy_start_inj_en", 32'(inj_en), 1);
        repeat (4) tick();
        check("busy_start_run1", 32'({run_done, dut_rst}), 32'h3);
        check("busy_start_cnt",  32'(run_cnt), 1);

        // Abort during OBS of run 5 (run index 4)
        repeat (29) tick();
        check("pre_abort_cnt", 32'(run_cnt), 4);
        check("pre_abort_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy",     32'(busy), 0);
        check("abort_run_done", 32'(run_done), 0);
        check("abort_run_cnt",  32'(run_cnt), 4);
        check("abort_stim",     32'(stim), 0);
        tick();
        check("abort_idle_hold", 32'({busy, done}), 0);

        // start + abort together in IDLE: stays idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("startabort_busy", 32'({busy, dut_rst}), 0);
        check("startabort_cnt",  32'(run_cnt), 4);

        // Start after abort clears counters and run 0 begins
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_abort_start", 32'({busy, dut_rst}), 32'h3);
        check("post_abort_cnt",   32'(run_cnt), 0);

        // Abort on the cycle that would enter INJ: no strobe
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_inj_en",   32'(inj_en), 0);
        check("abort_inj_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
